// File: rtl/bsg_comm_link_pattern_gen.sv
// Loopback traffic source: emits self-describing ring packets (seq, LFSR, seq-keyed bytes)
// on a valid/ready port, optionally spaced by idle gaps, and flags done after a fixed count.
module bsg_comm_link_pattern_gen #(
  parameter int unsigned channel_width_p = 8,
  parameter int unsigned ring_bytes_p    = 10,
  parameter int unsigned iterations_p    = 16,
  parameter int unsigned gap_cycles_p    = 0,
  parameter logic [15:0] lfsr_seed_p     = 16'hACE1,
  parameter int unsigned counter_width_p = 32
) (
  input  logic                                      clk,
  input  logic                                      reset_i,
  input  logic                                      en_i,
  input  logic                                      ready_i,
  output logic                                      v_o,
  output logic [ring_bytes_p*channel_width_p-1:0]   data_o,
  output logic [counter_width_p-1:0]                sent_count_o,
  output logic                                      done_o
);

  localparam int unsigned GapW = (gap_cycles_p > 1) ? $clog2(gap_cycles_p + 1) : 1;
  localparam logic [15:0] SeedEff = (lfsr_seed_p == 16'h0000) ? 16'h0001 : lfsr_seed_p;
  localparam logic [counter_width_p-1:0] IterCnt = counter_width_p'(iterations_p);
  localparam logic [GapW-1:0] GapInit = GapW'(gap_cycles_p);

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e                     state_q, state_d;
  logic [GapW-1:0]            gap_q, gap_d;
  logic [15:0]                seq_q, seq_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [counter_width_p-1:0] cnt_q, cnt_d;
  logic                       xfer;

  assign xfer = (state_q == StSend) && ready_i;

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    seq_d   = seq_q;
    lfsr_d  = lfsr_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      seq_d  = seq_q + 16'd1;
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      cnt_d  = cnt_q + counter_width_p'(1);
    end
    case (state_q)
      StIdle: if (en_i) state_d = StSend;
      StSend: begin
        // The offered packet is only withdrawn by a transfer, never by en_i.
        if (ready_i) begin
          if ((iterations_p != 0) && (cnt_d == IterCnt)) begin
            state_d = StDone;
          end else if (gap_cycles_p > 0) begin
            state_d = StGap;
            gap_d   = GapInit;
          end else begin
            state_d = en_i ? StSend : StIdle;
          end
        end
      end
      StGap: begin
        gap_d = gap_q - GapW'(1);
        if (gap_q == GapW'(1)) state_d = en_i ? StSend : StIdle;
      end
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q <= StIdle;
      gap_q   <= '0;
      seq_q   <= '0;
      lfsr_q  <= SeedEff;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      seq_q   <= seq_d;
      lfsr_q  <= lfsr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    data_o        = '0;
    data_o[15:0]  = seq_q;
    data_o[31:16] = lfsr_q;
    for (int k = 4; k < int'(ring_bytes_p); k++) begin
      data_o[k*channel_width_p +: channel_width_p] = channel_width_p'(8'(k) ^ seq_q[7:0]);
    end
  end

  assign v_o          = (state_q == StSend);
  assign done_o       = (state_q == StDone);
  assign sent_count_o = cnt_q;

endmodule
